// File: rtl/ble_tx_crc_serializer.sv
// BLE TX front end: serialises PDU bytes LSB-first on bit_tick, appends the CRC-24
// and drives the whitener's data/enable/init strobes.
module ble_tx_crc_serializer #(
  parameter logic [23:0] CRC_POLY = 24'h00065B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pdu_empty,
  input  logic [23:0] crc_init,
  input  logic        abort,
  input  logic        bit_tick,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        bit_out,
  output logic        bit_en,
  output logic        white_init,
  output logic        crc_phase,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PDU,
    S_CRC,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [23:0] crc_q;
  logic [7:0]  sr_q;
  logic [3:0]  sr_cnt_q;
  logic        sr_last_q;
  logic [7:0]  hold_q;
  logic        hold_v_q;
  logic        hold_last_q;
  logic        got_last_q;
  logic        empty_q;
  logic [4:0]  crc_cnt_q;
  logic        bit_out_q;
  logic        bit_en_q;
  logic        white_init_q;
  logic        crc_phase_q;
  logic        busy_q;
  logic        done_q;
  logic        underrun_q;

  logic        have_sr;
  logic        bit_avail;
  logic        pdu_bit;
  logic        starve;
  logic        accept;
  logic [23:0] crc_d;

  function automatic logic [23:0] bitrev24(input logic [23:0] v);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = v[23-i];
    return r;
  endfunction

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic d);
    logic fb;
    fb = d ^ c[23];
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

  // The next bit comes from the shift register, or straight from the holding
  // byte when the shift register has already drained.
  assign have_sr   = (sr_cnt_q != 4'd0);
  assign bit_avail = have_sr || hold_v_q;
  assign pdu_bit   = have_sr ? sr_q[0] : hold_q[0];
  assign starve    = bit_tick && !bit_avail;
  assign in_ready  = (state_q == S_PDU) && !hold_v_q && !got_last_q;
  assign accept    = in_valid && in_ready && !starve;
  assign crc_d     = crc_step(crc_q, pdu_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      crc_q        <= '0;
      sr_q         <= '0;
      sr_cnt_q     <= '0;
      sr_last_q    <= 1'b0;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      hold_last_q  <= 1'b0;
      got_last_q   <= 1'b0;
      empty_q      <= 1'b0;
      crc_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_en_q     <= 1'b0;
      white_init_q <= 1'b0;
      crc_phase_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      bit_en_q     <= 1'b0;
      white_init_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        crc_phase_q <= 1'b0;
        sr_cnt_q    <= '0;
        sr_last_q   <= 1'b0;
        hold_v_q    <= 1'b0;
        hold_last_q <= 1'b0;
        got_last_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q      <= S_LOAD;
              busy_q       <= 1'b1;
              white_init_q <= 1'b1;
              crc_q        <= bitrev24(crc_init);
              underrun_q   <= 1'b0;
              empty_q      <= pdu_empty;
              crc_phase_q  <= 1'b0;
              sr_cnt_q     <= '0;
              sr_last_q    <= 1'b0;
              hold_v_q     <= 1'b0;
              hold_last_q  <= 1'b0;
              got_last_q   <= 1'b0;
              crc_cnt_q    <= '0;
            end
          end
          S_LOAD: begin
            state_q <= empty_q ? S_CRC : S_PDU;
          end
          S_PDU: begin
            if (starve) begin
              underrun_q <= 1'b1;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              sr_cnt_q   <= '0;
              hold_v_q   <= 1'b0;
              got_last_q <= 1'b0;
            end else if (bit_tick) begin
              bit_out_q <= pdu_bit;
              bit_en_q  <= 1'b1;
              crc_q     <= crc_d;
              if (have_sr) begin
                sr_q     <= sr_q >> 1;
                sr_cnt_q <= sr_cnt_q - 4'd1;
                if (sr_cnt_q == 4'd1) begin
                  if (sr_last_q) begin
                    state_q   <= S_CRC;
                    crc_cnt_q <= '0;
                  end else if (hold_v_q) begin
                    sr_q      <= hold_q;
                    sr_cnt_q  <= 4'd8;
                    sr_last_q <= hold_last_q;
                    hold_v_q  <= 1'b0;
                  end
                end
              end else begin
                sr_q      <= {1'b0, hold_q[7:1]};
                sr_cnt_q  <= 4'd7;
                sr_last_q <= hold_last_q;
                hold_v_q  <= 1'b0;
              end
            end else if (!have_sr && hold_v_q) begin
              sr_q      <= hold_q;
              sr_cnt_q  <= 4'd8;
              sr_last_q <= hold_last_q;
              hold_v_q  <= 1'b0;
            end
            if (accept) begin
              hold_q      <= in_data;
              hold_v_q    <= 1'b1;
              hold_last_q <= in_last;
              got_last_q  <= in_last;
            end
          end
          S_CRC: begin
            if (bit_tick) begin
              bit_out_q   <= crc_q[23];
              bit_en_q    <= 1'b1;
              crc_phase_q <= 1'b1;
              crc_q       <= {crc_q[22:0], 1'b0};
              crc_cnt_q   <= crc_cnt_q + 5'd1;
              if (crc_cnt_q == 5'd23) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            crc_phase_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_en     = bit_en_q;
  assign white_init = white_init_q;
  assign crc_phase  = crc_phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule
